// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the RV32I-subset datapath: walks each instruction through
// fetch/decode/execute/memory/writeback phases, stalls on Mem_Ready and counts retirements.
module multicycle_control_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           OP6_0,
    input  logic [2:0]           funct3_2_0,
    input  logic                 funct7_5,
    input  logic                 Zero,
    input  logic                 Mem_Ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc1_0,
    output logic [1:0]           ALUSrcA1_0,
    output logic [1:0]           ALUSrcB1_0,
    output logic [1:0]           ImmSrc1_0,
    output logic                 RegWrite,
    output logic [2:0]           ALUControl2_0,
    output logic                 Illegal,
    output logic [CNT_WIDTH-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] count_reg;
    logic                 retire;
    logic                 pc_write_c, mem_write_c, ir_write_c, reg_write_c;
    logic                 alu_f3_ok;
    logic [2:0]           alu_dec_r, alu_dec_i;

    assign alu_f3_ok = (funct3_2_0 == 3'b000) || (funct3_2_0 == 3'b010) ||
                       (funct3_2_0 == 3'b110) || (funct3_2_0 == 3'b111);

    // Only R-type honours funct7_5 (sub); I-type 000 is always addi.
    always_comb begin
        alu_dec_i = 3'b000;
        case (funct3_2_0)
            3'b010:  alu_dec_i = 3'b101;
            3'b110:  alu_dec_i = 3'b011;
            3'b111:  alu_dec_i = 3'b010;
            default: alu_dec_i = 3'b000;
        endcase
        alu_dec_r = alu_dec_i;
        if (funct3_2_0 == 3'b000 && funct7_5)
            alu_dec_r = 3'b001;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= S_FETCH;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                count_reg <= count_reg + 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc1_0  = 2'b00;
        ALUSrcA1_0    = 2'b00;
        ALUSrcB1_0    = 2'b00;
        ImmSrc1_0     = 2'b00;
        ALUControl2_0 = 3'b000;
        Illegal       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ALUSrcB1_0   = 2'b10;
                ResultSrc1_0 = 2'b10;
                ir_write_c   = Mem_Ready;
                pc_write_c   = Mem_Ready;
                if (Mem_Ready)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA1_0 = 2'b01;
                ALUSrcB1_0 = 2'b01;
                ImmSrc1_0  = 2'b10;
                case (OP6_0)
                    OP_LW, OP_SW: state_next = (funct3_2_0 == 3'b010) ? S_MEMADR : S_ILLEGAL;
                    OP_R:         state_next = alu_f3_ok ? S_EXECUTER : S_ILLEGAL;
                    OP_I:         state_next = alu_f3_ok ? S_EXECUTEI : S_ILLEGAL;
                    OP_BEQ:       state_next = (funct3_2_0 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA1_0 = 2'b10;
                ALUSrcB1_0 = 2'b01;
                ImmSrc1_0  = (OP6_0 == OP_SW) ? 2'b01 : 2'b00;
                state_next = (OP6_0 == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (Mem_Ready)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc1_0 = 2'b01;
                reg_write_c  = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                if (Mem_Ready)
                    state_next = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA1_0    = 2'b10;
                ALUControl2_0 = alu_dec_r;
                state_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA1_0    = 2'b10;
                ALUSrcB1_0    = 2'b01;
                ALUControl2_0 = alu_dec_i;
                state_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA1_0    = 2'b10;
                ALUControl2_0 = 3'b001;
                pc_write_c    = Zero;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                // PC <- branch target computed in DECODE; ALU forms OldPC+4 for rd.
                ALUSrcA1_0 = 2'b01;
                ALUSrcB1_0 = 2'b10;
                ImmSrc1_0  = 2'b11;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: begin
                Illegal = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign retire = (state_next == S_FETCH) &&
                    ((state_reg == S_MEMWB) || (state_reg == S_MEMWRITE) ||
                     (state_reg == S_ALUWB) || (state_reg == S_BEQ));

    // Strobes are masked by RST directly so they drop the instant reset asserts.
    assign PCWrite    = RST & pc_write_c;
    assign MemWrite   = RST & mem_write_c;
    assign IRWrite    = RST & ir_write_c;
    assign RegWrite   = RST & reg_write_c;
    assign InstrCount = count_reg;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the RV32I-subset datapath. It replaces the single-cycle control decode and steps the shared datapath through instruction phases: fetch, decode, execute, memory, writeback.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Stalls on a memory-ready handshake and flags illegal instructions.
- Counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
OP6_0  input  7  instruction opcode, from the latched instruction register
funct3_2_0  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
Zero  input  1  ALU zero flag
Mem_Ready  input  1  unified memory access complete this cycle
PCWrite  output  1  PC register load enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register / OldPC load enable
ResultSrc1_0  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA1_0  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB1_0  output  2  SrcB select: 00 = RD2, 01 = ImmExt, 10 = constant 4
ImmSrc1_0  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
RegWrite  output  1  register file write enable
ALUControl2_0  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
Illegal  output  1  sticky illegal-instruction flag
InstrCount  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset and clocking: one clock domain CLK. RST is asynchronous and active-low.
- While RST = 0:
  - state = FETCH, InstrCount = 0, Illegal = 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Mux selects output FETCH values: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUControl 000, ResultSrc 10, ImmSrc 00.
- Outputs are combinational from state, plus Zero and Mem_Ready where noted. State registers only.
- Unlisted outputs per state: strobes = 0; selects = 0; ALUControl = 000 (add).
- FETCH:
  - AdrSrc 0, SrcA 00, SrcB 10, add, ResultSrc 10.
  - IRWrite = PCWrite = Mem_Ready.
  - Stay while Mem_Ready = 0; go to DECODE when 1.
- DECODE: SrcA 01, SrcB 01, ImmSrc 10, add (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - otherwise -> ILLEGAL
  - Also -> ILLEGAL if: ALU op with funct3 not in {000, 010, 110, 111}; beq with funct3 != 000; lw/sw with funct3 != 010.
- MEMADR: SrcA 10, SrcB 01, add, ImmSrc 00 (lw) or 01 (sw). Next MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc 1, ResultSrc 00. Hold until Mem_Ready = 1, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1. Next FETCH; retires.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1 held every cycle until Mem_Ready = 1. Next FETCH; retires.
- EXECUTER: SrcA 10, SrcB 00, ALU decode. Next ALUWB.
- EXECUTEI: SrcA 10, SrcB 01, ImmSrc 00, ALU decode. Next ALUWB.
- ALU decode by funct3:
  - 000: sub if R-type and funct7_5 = 1, else add (I-type ignores funct7_5)
  - 010: slt
  - 110: or
  - 111: and
- ALUWB: ResultSrc 00, RegWrite 1. Next FETCH; retires.
- BEQ: SrcA 10, SrcB 00, sub, ResultSrc 00, PCWrite = Zero. Next FETCH; retires.
- JAL: SrcA 01, SrcB 10, add, ResultSrc 00, ImmSrc 11, PCWrite 1. Next ALUWB (writes rd = PC+4); retirement counted at ALUWB only.
- ILLEGAL: all strobes 0, Illegal = 1. Absorbing until reset.
- Retirement: InstrCount += 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. Wraps modulo 2^CNT_WIDTH.
- Latency in cycles (Mem_Ready = 1 every cycle):
  - lw 5, sw 4, R/I 4, beq 3, jal 4.
  - Each Mem_Ready = 0 cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Reset asserted mid-instruction: immediate return to FETCH; no strobe asserted after the RST falling edge; counter cleared.

Test Plan:
- Reset: RST = 0 for 3 cycles with Mem_Ready = 1 -> PCWrite = IRWrite = MemWrite = RegWrite = 0, InstrCount = 0, Illegal = 0. After release, FETCH asserts IRWrite = PCWrite = 1.
- add x3,x1,x2 (OP 0110011, f3 000, f7_5 0) with Mem_Ready = 1 -> FETCH, DECODE, EXECUTER (ALUControl 000), ALUWB (RegWrite 1). InstrCount = 1 after 4 cycles. Repeat with f7_5 = 1 -> ALUControl 001.
- lw (0000011, f3 010) with Mem_Ready low for 2 cycles in MEMREAD -> 7 cycles total. RegWrite pulses once with ResultSrc 01; AdrSrc = 1 throughout MEMREAD.
- beq twice: Zero = 1 -> PCWrite = 1 in BEQ; Zero = 0 -> PCWrite = 0. Both take 3 cycles and increment InstrCount.
- jal (1101111) -> JAL cycle has PCWrite 1, ImmSrc 11, ALUSrcA 01, ALUSrcB 10. Then ALUWB RegWrite 1. InstrCount increments exactly once.
- Illegal/abort:
  - Opcode 1111111 -> Illegal = 1 from the cycle after DECODE; all strobes 0 for 10 cycles.
  - RST pulse -> Illegal = 0.
  - Separately, RST dropped during MEMWRITE -> MemWrite falls immediately, state FETCH.
